// File: rtl/mvm_frame_ctrl.sv
// rtl/mvm_frame_ctrl.sv - UART byte framing and sequencing controller for the MVM core
module mvm_frame_ctrl #(
    parameter int R              = 4,
    parameter int C              = 4,
    parameter int W_X            = 4,
    parameter int W_K            = 4,
    parameter int W_Y_OUT        = 10,
    parameter int BITS_PER_WORD  = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int W_BUS_KX       = R*C*W_K + C*W_X,
    parameter int W_BUS_Y        = R*W_Y_OUT
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_valid,
    input  logic [BITS_PER_WORD-1:0] s_data,
    output logic                     s_ready,
    output logic [W_BUS_KX-1:0]      mvm_kx,
    output logic                     mvm_start,
    input  logic                     mvm_done,
    input  logic [W_BUS_Y-1:0]       mvm_y,
    output logic                     m_valid,
    output logic [BITS_PER_WORD-1:0] m_data,
    input  logic                     m_ready,
    output logic                     busy,
    output logic                     overrun,
    output logic                     frame_err
);
    localparam int N_WORDS_KX = W_BUS_KX / BITS_PER_WORD;
    localparam int N_WORDS_Y  = W_BUS_Y / BITS_PER_WORD;
    localparam int CW = (N_WORDS_KX > 1) ? $clog2(N_WORDS_KX) : 1;
    localparam int WW = (N_WORDS_Y > 1) ? $clog2(N_WORDS_Y) : 1;
    localparam int IW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(N_WORDS_KX - 1);
    localparam logic [WW-1:0] WCNT_LAST = WW'(N_WORDS_Y - 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    localparam logic [1:0] ST_RECV  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_SEND  = 2'd3;

    generate
        if ((W_BUS_KX % BITS_PER_WORD) != 0 || (W_BUS_Y % BITS_PER_WORD) != 0) begin : g_bad_width
            $error("mvm_frame_ctrl: operand/result buses must be whole multiples of BITS_PER_WORD");
        end
    endgenerate

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idle_q, idle_d;
    logic [WW-1:0]       wcnt_q, wcnt_d;
    logic [W_BUS_KX-1:0] kx_q, kx_d;
    logic [W_BUS_Y-1:0]  y_q, y_d;
    logic                overrun_q, overrun_d;
    logic                frame_err_q, frame_err_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        wcnt_d      = wcnt_q;
        kx_d        = kx_q;
        y_d         = y_q;
        overrun_d   = overrun_q;
        frame_err_d = 1'b0;
        // The receiver cannot stall, so anything arriving outside RECV is lost.
        if (s_valid && state_q != ST_RECV) begin
            overrun_d = 1'b1;
        end
        case (state_q)
            ST_RECV: begin
                if (s_valid) begin
                    for (int i = 0; i < N_WORDS_KX; i++) begin
                        if (cnt_q == CW'(i)) begin
                            kx_d[i*BITS_PER_WORD +: BITS_PER_WORD] = s_data;
                        end
                    end
                    idle_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (TIMEOUT_CYCLES != 0 && cnt_q != '0) begin
                    if (idle_q == IDLE_LAST) begin
                        cnt_d       = '0;
                        idle_d      = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idle_d = idle_q + IW'(1);
                    end
                end
            end
            ST_START: state_d = ST_WAIT;
            ST_WAIT: begin
                if (mvm_done) begin
                    y_d     = mvm_y;
                    wcnt_d  = '0;
                    state_d = ST_SEND;
                end
            end
            default: begin
                if (m_ready) begin
                    if (wcnt_q == WCNT_LAST) begin
                        wcnt_d  = '0;
                        state_d = ST_RECV;
                    end else begin
                        wcnt_d = wcnt_q + WW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_RECV;
            cnt_q       <= '0;
            idle_q      <= '0;
            wcnt_q      <= '0;
            kx_q        <= '0;
            y_q         <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            wcnt_q      <= wcnt_d;
            kx_q        <= kx_d;
            y_q         <= y_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        m_data = '0;
        for (int i = 0; i < N_WORDS_Y; i++) begin
            if (wcnt_q == WW'(i)) begin
                m_data = y_q[i*BITS_PER_WORD +: BITS_PER_WORD];
            end
        end
    end

    assign s_ready   = (state_q == ST_RECV);
    assign mvm_start = (state_q == ST_START);
    assign m_valid   = (state_q == ST_SEND);
    assign busy      = !(state_q == ST_RECV && cnt_q == '0);
    assign mvm_kx    = kx_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
endmodule

// File: tb/tb_mvm_frame_ctrl.sv
// tb/tb_mvm_frame_ctrl.sv - self-checking bench for mvm_frame_ctrl
module tb_mvm_frame_ctrl;
    logic        clk = 1'b0;
    logic        rstn;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_ready;
    logic [79:0] mvm_kx;
    logic        mvm_start;
    logic        mvm_done;
    logic [39:0] mvm_y;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic        busy;
    logic        overrun;
    logic        frame_err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int frames_issued = 0;
    logic rand_rdy = 1'b0;
    logic [7:0] out_q[$];
    logic [7:0] fb[10];
    logic [7:0] exp_o[5];

    typedef struct {
        logic [7:0]  b0;
        logic [7:0]  step;
        int          gap;
        int          dly;
        logic [39:0] y;
        logic [79:0] exp_kx;
        logic [7:0]  exp_out[5];
    } vec_t;
    vec_t vecs[3];

    mvm_frame_ctrl #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mvm_kx(mvm_kx), .mvm_start(mvm_start), .mvm_done(mvm_done), .mvm_y(mvm_y),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .busy(busy), .overrun(overrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rstn && m_valid && m_ready) out_q.push_back(m_data);
        if (mvm_start) start_cnt++;
    end

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [79:0] pack_kx();
        logic [79:0] kx;
        for (int i = 0; i < 10; i++) kx[i*8 +: 8] = fb[i];
        return kx;
    endfunction

    // Signed K x X dot product per row; X elements in the low 16 bits, K row-major above.
    function automatic logic [39:0] mvm_model(input logic [79:0] kx);
        logic [39:0] y;
        int acc, kv, xv;
        y = '0;
        for (int r = 0; r < 4; r++) begin
            acc = 0;
            for (int c = 0; c < 4; c++) begin
                kv = $signed(kx[16 + (r*4 + c)*4 +: 4]);
                xv = $signed(kx[c*4 +: 4]);
                acc += kv * xv;
            end
            y[r*10 +: 10] = acc[9:0];
        end
        return y;
    endfunction

    task automatic send_bytes(input int lo, input int hi, input int gap);
        for (int i = lo; i < hi; i++) begin
            s_valid = 1'b1;
            s_data  = fb[i];
            tick();
            s_valid = 1'b0;
            if (i != hi - 1) repeat (gap) tick();
        end
    endtask

    // Entered right after the edge that accepted the final byte.
    task automatic do_mvm(input logic [79:0] exp_kx, input logic [39:0] y, input int dly,
                          input bit inject, input logic [7:0] first);
        frames_issued++;
        chk("start_latency", 80'(mvm_start), 80'd1);
        chk("kx_at_start", mvm_kx, exp_kx);
        chk("busy_in_start", 80'(busy), 80'd1);
        tick();
        chk("start_one_cycle", 80'(mvm_start), 80'd0);
        for (int k = 1; k < dly; k++) begin
            if (inject && k == 1) begin
                chk("s_ready_in_wait", 80'(s_ready), 80'd0);
                s_valid = 1'b1;
                s_data  = 8'hFF;
                tick();
                s_valid = 1'b0;
                chk("overrun_set", 80'(overrun), 80'd1);
            end else begin
                tick();
            end
        end
        mvm_done = 1'b1;
        mvm_y    = y;
        tick();
        mvm_done = 1'b0;
        chk("first_valid_latency", 80'(m_valid), 80'd1);
        chk("first_byte", 80'(m_data), 80'(first));
        chk("kx_held", mvm_kx, exp_kx);
    endtask

    task automatic finish_frame();
        int n = 0;
        while (out_q.size() < 5 && n < 500) begin
            tick();
            n++;
        end
        chk("out_bound", 80'(out_q.size() >= 5), 80'd1);
        repeat (2) tick();
        chk("out_count", 80'(out_q.size()), 80'd5);
        for (int i = 0; i < 5; i++) begin
            if (i < out_q.size()) chk("out_byte", 80'(out_q[i]), 80'(exp_o[i]));
        end
        chk("s_ready_after", 80'(s_ready), 80'd1);
        chk("busy_after", 80'(busy), 80'd0);
        chk("m_valid_after", 80'(m_valid), 80'd0);
        out_q.delete();
    endtask

    task automatic load_vec(input int v);
        for (int i = 0; i < 10; i++) fb[i] = vecs[v].b0 + 8'(i) * vecs[v].step;
        exp_o = vecs[v].exp_out;
    endtask

    task automatic run_vec(input int v);
        load_vec(v);
        send_bytes(0, 10, vecs[v].gap);
        do_mvm(vecs[v].exp_kx, vecs[v].y, vecs[v].dly, 1'b0, vecs[v].exp_out[0]);
        finish_frame();
    endtask

    initial begin
        logic [79:0] kx;
        logic [39:0] y;
        int sc0;

        vecs[0] = '{8'h01, 8'h01, 3, 4, 40'h12_3456_789A, 80'h0A09_0807_0605_0403_0201,
                    '{8'h9A, 8'h78, 8'h56, 8'h34, 8'h12}};
        vecs[1] = '{8'hA0, 8'h01, 0, 2, 40'hFE_DCBA_9876, 80'hA9A8_A7A6_A5A4_A3A2_A1A0,
                    '{8'h76, 8'h98, 8'hBA, 8'hDC, 8'hFE}};
        vecs[2] = '{8'hF0, 8'h11, 1, 1, 40'h00_0000_0001, 80'h8978_6756_4534_2312_01F0,
                    '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00}};

        rstn = 1'b0; s_valid = 1'b0; s_data = '0; mvm_done = 1'b0; mvm_y = '0; m_ready = 1'b1;
        repeat (2) tick();
        chk("rst_s_ready", 80'(s_ready), 80'd1);
        chk("rst_busy", 80'(busy), 80'd0);
        chk("rst_m_valid", 80'(m_valid), 80'd0);
        chk("rst_m_data", 80'(m_data), 80'd0);
        chk("rst_kx", mvm_kx, 80'd0);
        chk("rst_start", 80'(mvm_start), 80'd0);
        chk("rst_overrun", 80'(overrun), 80'd0);
        chk("rst_frame_err", 80'(frame_err), 80'd0);
        rstn = 1'b1;
        tick();

        for (int v = 0; v < 3; v++) run_vec(v);

        // Backpressure while the third result byte is on the bus.
        load_vec(0);
        send_bytes(0, 10, 3);
        do_mvm(vecs[0].exp_kx, vecs[0].y, 4, 1'b0, 8'h9A);
        tick();
        tick();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_valid", 80'(m_valid), 80'd1);
            chk("bp_data", 80'(m_data), 80'h56);
        end
        m_ready = 1'b1;
        finish_frame();

        // Partial frame times out after 16 idle cycles.
        for (int i = 0; i < 10; i++) fb[i] = 8'h11 + 8'(i);
        send_bytes(0, 4, 0);
        repeat (15) tick();
        chk("to_no_err_early", 80'(frame_err), 80'd0);
        chk("to_busy_early", 80'(busy), 80'd1);
        tick();
        chk("to_frame_err", 80'(frame_err), 80'd1);
        chk("to_busy_cleared", 80'(busy), 80'd0);
        tick();
        chk("to_pulse_one", 80'(frame_err), 80'd0);
        sc0 = start_cnt;
        run_vec(1);
        chk("to_one_start", 80'(start_cnt - sc0), 80'd1);

        // A byte on the 16th idle cycle rescues the frame.
        for (int i = 0; i < 10; i++) fb[i] = 8'h30 + 8'(i);
        send_bytes(0, 4, 0);
        repeat (15) tick();
        s_valid = 1'b1;
        s_data  = fb[4];
        tick();
        s_valid = 1'b0;
        chk("to_edge_no_err", 80'(frame_err), 80'd0);
        chk("to_edge_busy", 80'(busy), 80'd1);
        send_bytes(5, 10, 0);
        y = 40'h55_AA33_CC0F;
        for (int i = 0; i < 5; i++) exp_o[i] = y[i*8 +: 8];
        do_mvm(80'h3938_3736_3534_3332_3130, y, 3, 1'b0, 8'h0F);
        finish_frame();

        // Overrun: a byte during WAIT is dropped and the flag sticks.
        load_vec(0);
        send_bytes(0, 10, 0);
        do_mvm(vecs[0].exp_kx, vecs[0].y, 4, 1'b1, 8'h9A);
        finish_frame();
        chk("overrun_sticky", 80'(overrun), 80'd1);
        run_vec(2);
        chk("overrun_still", 80'(overrun), 80'd1);

        // Reset after two result bytes have left.
        load_vec(0);
        send_bytes(0, 10, 0);
        do_mvm(vecs[0].exp_kx, vecs[0].y, 4, 1'b0, 8'h9A);
        tick();
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mid_rst_m_valid", 80'(m_valid), 80'd0);
        chk("mid_rst_m_data", 80'(m_data), 80'd0);
        chk("mid_rst_overrun", 80'(overrun), 80'd0);
        chk("mid_rst_busy", 80'(busy), 80'd0);
        out_q.delete();
        run_vec(0);

        // Random soak against the behavioural MVM.
        for (int f = 0; f < 10; f++) begin
            for (int i = 0; i < 10; i++) fb[i] = 8'($urandom);
            kx = pack_kx();
            y  = mvm_model(kx);
            for (int i = 0; i < 5; i++) exp_o[i] = y[i*8 +: 8];
            rand_rdy = 1'b1;
            send_bytes(0, 10, $urandom_range(0, 2));
            do_mvm(kx, y, $urandom_range(1, 5), 1'b0, y[7:0]);
            finish_frame();
            rand_rdy = 1'b0;
            m_ready  = 1'b1;
        end
        chk("start_total", 80'(start_cnt), 80'(frames_issued));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
